// File: rtl/apb_conv_master.sv
// APB initiator: a small command FIFO feeds a SETUP/ACCESS sequencer with a
// PREADY-low timeout; each completed transfer lands in a one-entry response register.
module apb_conv_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [11:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    // APB
    output logic [11:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // ---------------- command FIFO ----------------
    cmd_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, push, pop;
    cmd_t             cmd_in;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    // Held low while in reset so the port reads all-zero until release.
    assign cmd_ready = HRESETn & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge HCLK) begin
        if (push) mem_q[wr_ptr_q] <= cmd_in;
    end

    // ---------------- sequencer ----------------
    state_t           state_q, state_d;
    cmd_t             hold_q, hold_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_to_q, rsp_to_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        hold_d      = hold_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        case (state_q)
            IDLE: begin
                // Issue only when the response slot is free, so completions never collide.
                if (!empty && (!rsp_valid_q || rsp_ready)) begin
                    pop    = 1'b1;
                    hold_d = mem_q[rd_ptr_q];
                    if (!hold_d.write) hold_d.wdata = '0;
                    wait_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = hold_q.write ? 32'h0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    rsp_to_d    = 1'b0;
                end else if (TIMEOUT != 0 && wait_q == TMO_W'(TIMEOUT)) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign PSEL        = (state_q != IDLE);
    assign PENABLE     = (state_q == ACCESS);
    assign PADDR       = hold_q.addr;
    assign PWRITE      = hold_q.write;
    assign PWDATA      = hold_q.wdata;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;
    assign busy_o      = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_apb_conv_master.sv
// Directed bench for apb_conv_master: APB slave model plus a scoreboard of
// expected addresses (checked at SETUP) and responses (checked at handshake).
module tb_apb_conv_master;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR, busy_o;

    apb_conv_master #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .busy_o(busy_o)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- APB slave model ----------------
    int          wait_states = 0;
    logic        hang = 1'b0;
    logic        slverr = 1'b0;
    logic [31:0] rdata_val = '0;
    int          acc_cnt;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)              acc_cnt <= 0;
        else if (PSEL && !PENABLE) acc_cnt <= 0;
        else if (PSEL && PENABLE)  acc_cnt <= acc_cnt + 1;
    end

    assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_states);
    assign PRDATA  = rdata_val;
    assign PSLVERR = PREADY && slverr;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t        exp_rsp_q[$];
    logic [11:0] exp_addr_q[$];
    rsp_t        e;

    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (PSEL && !PENABLE) begin
                chk("setup_expected", exp_addr_q.size() != 0, 1);
                if (exp_addr_q.size() != 0) chk("paddr_order", PADDR, exp_addr_q.pop_front());
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", exp_rsp_q.size() != 0, 1);
                if (exp_rsp_q.size() != 0) begin
                    e = exp_rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_timeout", rsp_timeout, e.to);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input logic et);
        bit ok = 0;
        exp_addr_q.push_back(a);
        exp_rsp_q.push_back('{er, ee, et});
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            ok = cmd_ready;
            @(posedge HCLK);
            if (ok) break;
        end
        chk("push_accepted", ok, 1);
        #1 cmd_valid = 1'b0;
    endtask

    // Finds the next SETUP, then checks address/direction over the ACCESS phase and its length.
    task automatic run_access(input string tag, input logic [11:0] a, input logic w, input int exp_n);
        int n = 0;
        bit found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK);
            if (PSEL && !PENABLE) begin found = 1; break; end
        end
        chk({tag, "_setup_seen"}, found, 1);
        if (!w) chk({tag, "_pwdata_read"}, PWDATA, 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK);
            if (!(PSEL && PENABLE)) break;
            n++;
            chk({tag, "_paddr_stable"}, PADDR, a);
            chk({tag, "_pwrite_stable"}, PWRITE, w);
        end
        chk({tag, "_access_cycles"}, n, exp_n);
    endtask

    task automatic drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge HCLK);
            if (exp_rsp_q.size() == 0 && exp_addr_q.size() == 0 && !busy_o) begin ok = 1; break; end
        end
        chk({tag, "_drained"}, ok, 1);
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // reset state
        #12;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        @(posedge HCLK); #1 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_busy", busy_o, 0);
        @(posedge HCLK); #1;

        // write latency: SETUP N+2, ACCESS N+3, response N+4
        send(1'b1, 12'h000, 32'h0011_2233, 32'h0, 1'b0, 1'b0);
        @(negedge HCLK);
        chk("lat_n1_idle", PSEL, 0);
        @(negedge HCLK);
        chk("lat_n2_psel", PSEL, 1);
        chk("lat_n2_penable", PENABLE, 0);
        chk("lat_n2_paddr", PADDR, 12'h000);
        chk("lat_n2_pwrite", PWRITE, 1);
        chk("lat_n2_pwdata", PWDATA, 32'h0011_2233);
        @(negedge HCLK);
        chk("lat_n3_psel", PSEL, 1);
        chk("lat_n3_penable", PENABLE, 1);
        @(negedge HCLK);
        chk("lat_n4_rsp_valid", rsp_valid, 1);
        chk("lat_n4_rsp_rdata", rsp_rdata, 0);
        chk("lat_n4_rsp_err", rsp_err, 0);
        drain("t1");

        // read with 3 wait states
        wait_states = 3;
        rdata_val = 32'hCAFE_0042;
        send(1'b0, 12'h014, 32'hFFFF_FFFF, 32'hCAFE_0042, 1'b0, 1'b0);
        run_access("rd_ws", 12'h014, 1'b0, 4);
        drain("t2");
        wait_states = 0;

        // timeout: 16 wait cycles then abort on the 17th ACCESS cycle
        hang = 1'b1;
        rdata_val = 32'hDEAD_BEEF;
        send(1'b0, 12'h008, 32'h0, 32'h0, 1'b1, 1'b1);
        run_access("tmo", 12'h008, 1'b0, 17);
        hang = 1'b0;
        drain("t3a");
        send(1'b1, 12'h004, 32'h55AA_55AA, 32'h0, 1'b0, 1'b0);
        drain("t3b");

        // back-pressure: one transfer completes, FIFO fills, rest stall
        rsp_ready = 1'b0;
        send(1'b1, 12'h000, 32'h1, 32'h0, 1'b0, 1'b0);
        send(1'b1, 12'h004, 32'h2, 32'h0, 1'b0, 1'b0);
        send(1'b1, 12'h008, 32'h3, 32'h0, 1'b0, 1'b0);
        send(1'b1, 12'h00C, 32'h4, 32'h0, 1'b0, 1'b0);
        send(1'b1, 12'h014, 32'h5, 32'h0, 1'b0, 1'b0);
        @(negedge HCLK);
        chk("full_cmd_ready", cmd_ready, 0);
        // offer an extra command while full; it must not be taken
        @(posedge HCLK); #1;
        cmd_write = 1'b1; cmd_addr = 12'h3FC; cmd_wdata = 32'h6; cmd_valid = 1'b1;
        repeat (8) @(negedge HCLK);
        chk("stall_psel", PSEL, 0);
        chk("stall_rsp_valid", rsp_valid, 1);
        chk("stall_busy", busy_o, 1);
        chk("stall_one_done", exp_addr_q.size(), 4);
        @(posedge HCLK); #1 cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain("t4");

        // slave error on write
        slverr = 1'b1;
        send(1'b1, 12'h00C, 32'h0000_0001, 32'h0, 1'b1, 1'b0);
        drain("t5");
        slverr = 1'b0;

        // reset during ACCESS with a second command queued
        hang = 1'b1;
        send(1'b0, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0);
        send(1'b1, 12'h004, 32'h7, 32'h0, 1'b0, 1'b0);
        begin
            bit in_acc = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge HCLK);
                if (PSEL && PENABLE) begin in_acc = 1; break; end
            end
            chk("mid_reset_in_access", in_acc, 1);
        end
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_rst_psel", PSEL, 0);
        chk("mid_rst_penable", PENABLE, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy_o, 0);
        exp_addr_q.delete();
        exp_rsp_q.delete();
        hang = 1'b0;
        @(posedge HCLK); #1 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy_o, 0);
        repeat (5) @(negedge HCLK);
        chk("post_rst_idle_psel", PSEL, 0);
        chk("post_rst_no_rsp", rsp_valid, 0);
        @(posedge HCLK); #1;

        // normal operation after reset
        rdata_val = 32'h1234_5678;
        send(1'b0, 12'h014, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
